hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and execute-sequencing controller for the 5-stage RISC-V core. It generates forwarding selects for the execute-stage ALU operands, load-use stalls and branch/jump flushes. It also sequences multi-cycle execute operations, holding F/D/E and bubbling M until the operation completes. It sits beside the decode/execute/memory stage registers and drives their stall/flush enables.

Parameters:
MC_CYCLES, 4, total cycles a multi-cycle op occupies E; legal range >= 2
CNT_W, $clog2(MC_CYCLES), width of the busy counter

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset
Rs1D  in  5  rs1 of instruction in D
Rs2D  in  5  rs2 of instruction in D
Rs1E  in  5  rs1 of instruction in E
Rs2E  in  5  rs2 of instruction in E
RdE  in  5  rd of instruction in E
RdM  in  5  rd of instruction in M
RdW  in  5  rd of instruction in W
RegWriteM  in  1  M instruction writes the register file
RegWriteW  in  1  W instruction writes the register file
LoadE  in  1  E instruction is a load (ResultSrcE selects memory)
PCSrcE  in  1  taken branch or jump resolved in E
MultiCycleE  in  1  E instruction is a multi-cycle op
ForwardAE  out  2  SrcA select: 00 RD1E, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  SrcB select, same encoding
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register
FlushM  out  1  clear E/M register (bubble)
McStartE  out  1  one-cycle pulse: multi-cycle unit latches operands
McDoneE  out  1  one-cycle pulse: multi-cycle result valid, op leaves E

Behaviour:
- Forwarding is combinational. ForwardAE=10 when RegWriteM && RdM!=0 && RdM==Rs1E; else 01 when RegWriteW && RdW!=0 && RdW==Rs1E; else 00. M has priority over W. ForwardBE uses the same rules on Rs2E. x0 is never forwarded.
- lwStall = LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- FSM states: IDLE, BUSY. Counter cnt is CNT_W bits wide.
- trig = (state==IDLE) && MultiCycleE && !PCSrcE.
- IDLE: on trig, McStartE=1, load cnt=MC_CYCLES-2, next state BUSY.
- BUSY: if cnt!=0, decrement. If cnt==0, this is the release cycle: McDoneE=1 and next state is IDLE. In IDLE, MultiCycleE is honoured from the following cycle, so back-to-back multi-cycle ops cost MC_CYCLES each with no gap.
- mcStall = trig || (state==BUSY && cnt!=0). Total stall cycles per op = MC_CYCLES-1; E occupancy = MC_CYCLES.
- Output equations:
  - StallF = StallD = lwStall || mcStall
  - StallE = mcStall
  - FlushM = mcStall
  - FlushD = PCSrcE
  - FlushE = PCSrcE || (lwStall && !mcStall). FlushE is never asserted together with StallE, so the held op is not destroyed.
- PCSrcE and MultiCycleE high together is illegal. The RTL suppresses trig and the flush wins. An SVA assertion flags the condition.
- Forward selects may change while BUSY. The multi-cycle unit must capture operands on McStartE.
- Reset (rst low, any time including mid-BUSY): state=IDLE, cnt=0 immediately. All outputs then follow the combinational equations in IDLE, with McDoneE=0.
- With all inputs zero, every output is 0.

Decomposition:
- Shared package hazard_pkg: forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and the FSM state enum.
- One sub-module, fwd_sel: pure combinational per-operand forwarding select, instantiated for A and B.

Test Plan:
- Forward priority:
  - RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5 -> ForwardAE=10.
  - Drop RegWriteM -> ForwardAE=01.
  - Rs1E=0 with RdM=0, RegWriteM=1 -> ForwardAE=00.
- Load-use: LoadE=1, RdE=7, Rs2D=7 for one cycle -> StallF=StallD=FlushE=1 that cycle only. LoadE=1, RdE=0, Rs1D=0 -> no stall.
- Branch flush: PCSrcE=1 -> FlushD=FlushE=1, StallF=0, no McStartE even if MultiCycleE=1.
- Multi-cycle, MC_CYCLES=4, MultiCycleE high from cycle 0:
  - cycle 0: McStartE=1
  - cycles 0-2: StallF/StallD/StallE/FlushM=1
  - cycle 3: McDoneE=1, stalls 0
  - cycle 4: second op starts McStartE=1
- Overlap: lwStall condition true during cycles 1-2 of the multi-cycle op -> StallE=1, FlushE=0. After release, the load-use stall applies normally.
- Reset mid-op: rst low in cycle 1 of BUSY with MultiCycleE=0 -> next cycle state IDLE, all stalls 0, McDoneE never pulses.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller:
// forwarding-select codes and the multi-cycle sequencer state encoding.
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline register addresses/flags into the hazard controller
// and the stall/flush/forward controls it returns to the stage registers.
interface hazard_ctrl_if;

   logic [4:0] Rs1D;
   logic [4:0] Rs2D;
   logic [4:0] Rs1E;
   logic [4:0] Rs2E;
   logic [4:0] RdE;
   logic [4:0] RdM;
   logic [4:0] RdW;
   logic       RegWriteM;
   logic       RegWriteW;
   logic       LoadE;
   logic       PCSrcE;
   logic       MultiCycleE;

   logic [1:0] ForwardAE;
   logic [1:0] ForwardBE;
   logic       StallF;
   logic       StallD;
   logic       StallE;
   logic       FlushD;
   logic       FlushE;
   logic       FlushM;
   logic       McStartE;
   logic       McDoneE;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output RegWriteM, RegWriteW, LoadE, PCSrcE, MultiCycleE,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE,
      input  FlushD, FlushE, FlushM, McStartE, McDoneE
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  RegWriteM, RegWriteW, LoadE, PCSrcE, MultiCycleE,
      output ForwardAE, ForwardBE, StallF, StallD, StallE,
      output FlushD, FlushE, FlushM, McStartE, McDoneE
   );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding select for the execute stage: M beats W,
// and x0 is never forwarded.
module fwd_sel
   import hazard_pkg::*;
(
   input  logic       reg_write_m,
   input  logic [4:0] rd_m,
   input  logic       reg_write_w,
   input  logic [4:0] rd_w,
   input  logic [4:0] rs_e,
   output logic [1:0] fwd
);

   always_comb begin
      fwd = FWD_RF;
      if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
         fwd = FWD_MEM;
      end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
         fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use stall, branch flush and
// sequencing of multi-cycle execute ops that hold F/D/E while bubbling M.
//
// state | meaning
// IDLE  | no multi-cycle op in flight; a new one is accepted here
// BUSY  | op occupies E; cnt counts down to the release cycle (cnt==0)
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MC_CYCLES = 4,
   parameter int CNT_W     = $clog2(MC_CYCLES)
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             trig;
   logic             lw_stall;
   logic             mc_stall;
   logic             mc_start;
   logic             mc_done;

   fwd_sel u_fwd_a (
      .reg_write_m (hz.RegWriteM),
      .rd_m        (hz.RdM),
      .reg_write_w (hz.RegWriteW),
      .rd_w        (hz.RdW),
      .rs_e        (hz.Rs1E),
      .fwd         (hz.ForwardAE)
   );

   fwd_sel u_fwd_b (
      .reg_write_m (hz.RegWriteM),
      .rd_m        (hz.RdM),
      .reg_write_w (hz.RegWriteW),
      .rd_w        (hz.RdW),
      .rs_e        (hz.Rs2E),
      .fwd         (hz.ForwardBE)
   );

   assign lw_stall = hz.LoadE && (hz.RdE != 5'd0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

   // A taken branch kills the op in E, so it must not start the sequencer.
   assign trig     = (state_q == ST_IDLE) && hz.MultiCycleE && !hz.PCSrcE;
   assign mc_stall = trig || ((state_q == ST_BUSY) && (cnt_q != '0));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mc_start = 1'b0;
      mc_done  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (trig) begin
               mc_start = 1'b1;
               cnt_d    = CNT_W'(MC_CYCLES - 2);
               state_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               mc_done = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign hz.StallF   = lw_stall || mc_stall;
   assign hz.StallD   = lw_stall || mc_stall;
   assign hz.StallE   = mc_stall;
   assign hz.FlushM   = mc_stall;
   assign hz.FlushD   = hz.PCSrcE;
   // A held multi-cycle op in D/E must survive a coincident load-use hazard.
   assign hz.FlushE   = hz.PCSrcE || (lw_stall && !mc_stall);
   assign hz.McStartE = mc_start;
   assign hz.McDoneE  = mc_done;

   a_no_branch_with_mc: assert property (
      @(posedge clk) disable iff (!rst) !(hz.PCSrcE && hz.MultiCycleE)
   ) else $error("hazard_ctrl: PCSrcE and MultiCycleE high together");

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding priority, load-use stall,
// branch flush, multi-cycle sequencing, overlap and asynchronous reset.
module tb_hazard_ctrl;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   hazard_ctrl_if hz ();

   hazard_ctrl #(.MC_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst_n),
      .hz  (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control bits: {StallF,StallD,StallE,FlushD,FlushE,FlushM,McStartE,McDoneE}
   function automatic logic [7:0] ctl();
      return {hz.StallF, hz.StallD, hz.StallE, hz.FlushD,
              hz.FlushE, hz.FlushM, hz.McStartE, hz.McDoneE};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
      hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
      hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.LoadE = 1'b0;
      hz.PCSrcE = 1'b0; hz.MultiCycleE = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      #2;
      chk("reset_ctl", ctl(), 8'h00);
      chk("reset_fwd_a", {6'd0, hz.ForwardAE}, 8'h00);
      chk("reset_fwd_b", {6'd0, hz.ForwardBE}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      chk("idle_zero_ctl", ctl(), 8'h00);

      // forwarding priority
      hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.RegWriteW = 1'b1; hz.RdW = 5'd5;
      hz.Rs1E = 5'd5; hz.Rs2E = 5'd3;
      #1;
      chk("fwd_a_mem_prio", {6'd0, hz.ForwardAE}, 8'h02);
      chk("fwd_b_none", {6'd0, hz.ForwardBE}, 8'h00);
      hz.RegWriteM = 1'b0;
      #1;
      chk("fwd_a_wb", {6'd0, hz.ForwardAE}, 8'h01);
      hz.Rs2E = 5'd5;
      #1;
      chk("fwd_b_wb", {6'd0, hz.ForwardBE}, 8'h01);
      hz.RegWriteM = 1'b1; hz.RdM = 5'd3; hz.Rs2E = 5'd3;
      #1;
      chk("fwd_b_mem", {6'd0, hz.ForwardBE}, 8'h02);
      hz.RdM = 5'd0; hz.RdW = 5'd0; hz.Rs1E = 5'd0;
      #1;
      chk("fwd_a_x0", {6'd0, hz.ForwardAE}, 8'h00);
      hz.RegWriteM = 1'b0; hz.RdM = 5'd9; hz.Rs1E = 5'd9;
      #1;
      chk("fwd_a_no_regwrite", {6'd0, hz.ForwardAE}, 8'h00);
      clear_inputs();

      // load-use
      cyc();
      hz.LoadE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
      #1;
      chk("lw_stall", ctl(), 8'hC8);
      cyc();
      hz.LoadE = 1'b0;
      #1;
      chk("lw_stall_gone", ctl(), 8'h00);
      hz.LoadE = 1'b1; hz.RdE = 5'd0; hz.Rs1D = 5'd0; hz.Rs2D = 5'd0;
      #1;
      chk("lw_x0_no_stall", ctl(), 8'h00);
      clear_inputs();

      // branch flush, MultiCycleE dropped before the clock edge
      cyc();
      hz.PCSrcE = 1'b1; hz.MultiCycleE = 1'b1;
      #1;
      chk("branch_flush", ctl(), 8'h18);
      #1;
      clear_inputs();
      cyc();
      chk("branch_no_mc_start", ctl(), 8'h00);

      // back-to-back multi-cycle ops
      hz.MultiCycleE = 1'b1;
      #1;
      chk("mc_cycle0", ctl(), 8'hE6);
      cyc();
      chk("mc_cycle1", ctl(), 8'hE4);
      cyc();
      chk("mc_cycle2", ctl(), 8'hE4);
      cyc();
      chk("mc_cycle3_done", ctl(), 8'h01);
      cyc();
      chk("mc_cycle4_restart", ctl(), 8'hE6);

      // load-use overlapping the held op
      cyc();
      hz.LoadE = 1'b1; hz.RdE = 5'd7; hz.Rs1D = 5'd7;
      #1;
      chk("overlap_c1", ctl(), 8'hE4);
      cyc();
      chk("overlap_c2", ctl(), 8'hE4);
      cyc();
      hz.MultiCycleE = 1'b0;
      #1;
      chk("overlap_release", ctl(), 8'hC9);
      cyc();
      chk("overlap_lw_after", ctl(), 8'hC8);
      clear_inputs();
      #1;
      chk("overlap_clear", ctl(), 8'h00);

      // reset mid-op
      cyc();
      hz.MultiCycleE = 1'b1;
      #1;
      chk("rst_op_start", ctl(), 8'hE6);
      cyc();
      hz.MultiCycleE = 1'b0;
      #1;
      chk("rst_op_busy", ctl(), 8'hE4);
      rst_n = 1'b0;
      #1;
      chk("rst_async_idle", ctl(), 8'h00);
      cyc();
      chk("rst_held", ctl(), 8'h00);
      rst_n = 1'b1;
      cyc();
      chk("rst_no_done_1", ctl(), 8'h00);
      cyc();
      chk("rst_no_done_2", ctl(), 8'h00);
      cyc();
      chk("rst_no_done_3", ctl(), 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
